// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg
// Shared definitions for the HI/LO multiply/divide unit:
//   - SPECIAL and SPECIAL2 funct codes (6-bit MIPS encoding)
//   - FSM state enum and operation-class enum
//   - is_signed_op(): selects the signed variants of each operation
// Optional feature macro: HILO_DIV_EN (div/divu support). The package
// itself does not depend on it.
package hilo_muldiv_pkg;

  // SPECIAL funct space
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  // SPECIAL2 funct space
  localparam logic [5:0] F2_MADD  = 6'b000000;
  localparam logic [5:0] F2_MADDU = 6'b000001;
  localparam logic [5:0] F2_MSUB  = 6'b000100;
  localparam logic [5:0] F2_MSUBU = 6'b000101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIN
  } state_e;

  typedef enum logic [2:0] {
    OP_MOVE,
    OP_MUL,
    OP_MACC_ADD,
    OP_MACC_SUB,
    OP_DIV
  } op_class_e;

  // True for the two's-complement flavours (mult, div, madd, msub).
  function automatic logic is_signed_op(input logic special2, input logic [5:0] f6);
    if (special2) begin
      return (f6 == F2_MADD) || (f6 == F2_MSUB);
    end
    return (f6 == F_MULT) || (f6 == F_DIV);
  endfunction

endpackage

// File: rtl/hilo_iter_core.sv
// hilo_iter_core
// Shared iterative datapath: unsigned shift-add multiply or unsigned
// restoring division, one step per enabled cycle, plus the step counter.
// The 2*DATA_W working register is {upper, lower}:
//   multiply: upper = partial product, lower = multiplier shifting out
//   divide:   upper = partial remainder, lower = dividend -> quotient
// Ports:
//   Clk, Reset  clock / asynchronous active-high reset
//   load        initialise: upper = 0, lower = a_mag, latch b_mag
//   step_en     perform one iteration step
//   mode_div    0 = multiply step, 1 = divide step
//   a_mag       multiplier / dividend magnitude
//   b_mag       multiplicand / divisor magnitude
//   raw_result  {upper, lower} working register
//   last_step   high during the DATA_W-th step
// Optional feature macro: HILO_DIV_EN (divide step is only built when set).
module hilo_iter_core #(
  parameter int DATA_W = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  load,
  input  logic                  step_en,
  input  logic                  mode_div,
  input  logic [DATA_W-1:0]     a_mag,
  input  logic [DATA_W-1:0]     b_mag,
  output logic [2*DATA_W-1:0]   raw_result,
  output logic                  last_step
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [2*DATA_W-1:0] acc_d, acc_q;
  logic [DATA_W-1:0]   b_d, b_q;
  logic [CNT_W-1:0]    cnt_d, cnt_q;
  logic [DATA_W:0]     mul_sum;
`ifdef HILO_DIV_EN
  logic [DATA_W:0]     div_shift;
  logic [DATA_W:0]     div_diff;
`endif

  always_comb begin
    acc_d   = acc_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    // Carry out of the add lands in the top bit before the right shift.
    mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, (acc_q[0] ? b_q : {DATA_W{1'b0}})};
`ifdef HILO_DIV_EN
    // Shifted remainder needs DATA_W+1 bits; a clear top bit of the
    // difference means the trial subtraction succeeded.
    div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    div_diff  = div_shift - {1'b0, b_q};
`endif
    if (load) begin
      acc_d = {{DATA_W{1'b0}}, a_mag};
      b_d   = b_mag;
      cnt_d = '0;
    end else if (step_en) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (!mode_div) begin
        acc_d = {mul_sum, acc_q[DATA_W-1:1]};
      end
`ifdef HILO_DIV_EN
      else if (!div_diff[DATA_W]) begin
        acc_d = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
      end else begin
        acc_d = {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
      end
`endif
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign raw_result = acc_q;
  assign last_step  = step_en && (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
// Multi-cycle HI/LO unit: decodes SPECIAL/SPECIAL2 funct directly and
// executes mult(u), madd(u), msub(u), div(u), mthi, mtlo, mfhi, mflo.
// Iterative ops take DATA_W+1 cycles (start/busy/done); moves take one.
// Ports:
//   Clk, Reset          clock / asynchronous active-high reset
//   start               request, accepted only while busy=0
//   special2, funct     operation select (FUNCT_W >= 6, upper bits must be 0)
//   rs_val, rt_val      operands
//   busy                iterative operation in progress
//   done                one-cycle completion pulse
//   result              registered mfhi/mflo data
//   hi, lo              architectural HI/LO
//   illegal             one-cycle pulse for an unsupported funct
//   div_zero            one-cycle pulse with done on divide by zero
// Optional feature macro: HILO_DIV_EN. When undefined div/divu decode as
// illegal, the DIV path is not built and div_zero is tied to 0.
module hilo_muldiv_unit #(
  parameter int DATA_W  = 32,
  parameter int FUNCT_W = 6
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic               special2,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [DATA_W-1:0]  rs_val,
  input  logic [DATA_W-1:0]  rt_val,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  result,
  output logic [DATA_W-1:0]  hi,
  output logic [DATA_W-1:0]  lo,
  output logic               illegal,
  output logic               div_zero
);

  import hilo_muldiv_pkg::*;

  state_e              state_d, state_q;
  op_class_e           op_d, op_q;
  logic                neg_d, neg_q;
  logic [DATA_W-1:0]   hi_d, hi_q, lo_d, lo_q, result_d, result_q;
  logic                done_d, done_q, illegal_d, illegal_q;
`ifdef HILO_DIV_EN
  logic                rneg_d, rneg_q, dz_d, dz_q, div_zero_d, div_zero_q;
`endif

  logic [5:0]          f6;
  logic                funct_hi_zero;
  logic                dec_valid, dec_signed, a_neg, b_neg;
  op_class_e           dec_class;
  logic [DATA_W-1:0]   a_mag, b_mag, core_a;
  logic                core_load, core_step, core_mode_div, core_last;
  logic [2*DATA_W-1:0] core_raw, prod_fix;

  assign f6            = funct[5:0];
  assign funct_hi_zero = ((funct >> 6) == '0);

  // Decode funct into an operation class; anything else is illegal.
  always_comb begin
    dec_valid = 1'b0;
    dec_class = OP_MOVE;
    if (funct_hi_zero) begin
      if (special2) begin
        case (f6)
          F2_MADD, F2_MADDU: begin dec_valid = 1'b1; dec_class = OP_MACC_ADD; end
          F2_MSUB, F2_MSUBU: begin dec_valid = 1'b1; dec_class = OP_MACC_SUB; end
          default: ;
        endcase
      end else begin
        case (f6)
          F_MFHI, F_MTHI, F_MFLO, F_MTLO: begin dec_valid = 1'b1; dec_class = OP_MOVE; end
          F_MULT, F_MULTU:                begin dec_valid = 1'b1; dec_class = OP_MUL;  end
`ifdef HILO_DIV_EN
          F_DIV, F_DIVU:                  begin dec_valid = 1'b1; dec_class = OP_DIV;  end
`endif
          default: ;
        endcase
      end
    end
  end

  assign dec_signed = is_signed_op(special2, f6);
  assign a_neg      = dec_signed & rs_val[DATA_W-1];
  assign b_neg      = dec_signed & rt_val[DATA_W-1];
  assign a_mag      = a_neg ? -rs_val : rs_val;
  assign b_mag      = b_neg ? -rt_val : rt_val;

  // The core works on magnitudes; the sign is restored here at FIN.
  assign prod_fix      = neg_q ? -core_raw : core_raw;
  assign core_mode_div = (op_q == OP_DIV);

  hilo_iter_core #(.DATA_W(DATA_W)) u_core (
    .Clk        (Clk),
    .Reset      (Reset),
    .load       (core_load),
    .step_en    (core_step),
    .mode_div   (core_mode_div),
    .a_mag      (core_a),
    .b_mag      (b_mag),
    .raw_result (core_raw),
    .last_step  (core_last)
  );

  // FSM next-state, HI/LO update and one-cycle pulses.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    neg_d      = neg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    result_d   = result_q;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    core_load  = 1'b0;
    core_step  = 1'b0;
    core_a     = a_mag;
`ifdef HILO_DIV_EN
    rneg_d     = rneg_q;
    dz_d       = dz_q;
    div_zero_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!dec_valid) begin
            illegal_d = 1'b1;
          end else begin
            case (dec_class)
              OP_MOVE: begin
                done_d = 1'b1;
                case (f6)
                  F_MTHI:  hi_d     = rs_val;
                  F_MTLO:  lo_d     = rs_val;
                  F_MFHI:  result_d = hi_q;
                  default: result_d = lo_q;
                endcase
              end
`ifdef HILO_DIV_EN
              OP_DIV: begin
                op_d      = OP_DIV;
                core_load = 1'b1;
                neg_d     = a_neg ^ b_neg;
                rneg_d    = a_neg;
                if (rt_val == '0) begin
                  // Park raw rs_val in the core so FIN can return it in HI.
                  dz_d    = 1'b1;
                  core_a  = rs_val;
                  state_d = ST_FIN;
                end else begin
                  dz_d    = 1'b0;
                  state_d = ST_DIV;
                end
              end
`endif
              default: begin
                op_d      = dec_class;
                neg_d     = a_neg ^ b_neg;
                core_load = 1'b1;
                state_d   = ST_MUL;
              end
            endcase
          end
        end
      end
      ST_MUL: begin
        core_step = 1'b1;
        if (core_last) state_d = ST_FIN;
      end
`ifdef HILO_DIV_EN
      ST_DIV: begin
        core_step = 1'b1;
        if (core_last) state_d = ST_FIN;
      end
`endif
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        case (op_q)
          OP_MUL:      {hi_d, lo_d} = prod_fix;
          OP_MACC_ADD: {hi_d, lo_d} = {hi_q, lo_q} + prod_fix;
          OP_MACC_SUB: {hi_d, lo_d} = {hi_q, lo_q} - prod_fix;
`ifdef HILO_DIV_EN
          OP_DIV: begin
            if (dz_q) begin
              lo_d       = '1;
              hi_d       = core_raw[DATA_W-1:0];
              div_zero_d = 1'b1;
            end else begin
              lo_d = neg_q  ? -core_raw[DATA_W-1:0]        : core_raw[DATA_W-1:0];
              hi_d = rneg_q ? -core_raw[2*DATA_W-1:DATA_W] : core_raw[2*DATA_W-1:DATA_W];
            end
          end
`endif
          default: ;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_MOVE;
      neg_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
`ifdef HILO_DIV_EN
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      div_zero_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      neg_q      <= neg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      result_q   <= result_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
`ifdef HILO_DIV_EN
      rneg_q     <= rneg_d;
      dz_q       <= dz_d;
      div_zero_q <= div_zero_d;
`endif
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign result  = result_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign illegal = illegal_q;
`ifdef HILO_DIV_EN
  assign div_zero = div_zero_q;
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit
// Directed bench for hilo_muldiv_unit (DATA_W=32). Each step drives one
// request and compares outputs against hand-computed values. Divide
// vectors are selected by HILO_DIV_EN to match the build under test.
module tb_hilo_muldiv_unit;

  localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010, MTLO = 6'b010011;
  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;
  localparam logic [5:0] MADD = 6'b000000, MSUB = 6'b000100;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic        special2;
  logic [5:0]  funct;
  logic [31:0] rs_val, rt_val;
  logic        busy, done, illegal, div_zero;
  logic [31:0] result, hi, lo;

  int checks = 0;
  int failures = 0;
  int cycles;
  int busyCycles;
  logic sawIllegal;

  hilo_muldiv_unit #(.DATA_W(32), .FUNCT_W(6)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (start),
    .special2 (special2),
    .funct    (funct),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .hi       (hi),
    .lo       (lo),
    .illegal  (illegal),
    .div_zero (div_zero)
  );

  // 10 ns clock
  always #5 Clk = ~Clk;

  // Compare one observed value to its expected value.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Present a request for one edge; returns 1 ns after that edge.
  task automatic applyStimulus(input logic s2, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    special2 = s2;
    funct    = f;
    rs_val   = a;
    rt_val   = b;
    @(posedge Clk); #1;
    start    = 1'b0;
  endtask

  // Wait for done with a cycle bound; counts edges and busy samples.
  task automatic waitDone(output int nCycles, output int nBusy, output logic illSeen);
    nCycles = 0;
    nBusy   = 0;
    illSeen = 1'b0;
    while (!done && nCycles < 100) begin
      if (busy) nBusy++;
      if (illegal) illSeen = 1'b1;
      @(posedge Clk); #1;
      nCycles++;
    end
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; special2 = 1'b0; funct = '0; rs_val = '0; rt_val = '0;
    #12;
    $display("[TB] reset state");
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_hilo", {hi, lo}, 64'd0);
    checkOutput("rst_result", {32'd0, result}, 64'd0);
    checkOutput("rst_illegal", {62'd0, illegal, div_zero}, 64'd0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    $display("[TB] mult -3*7");
    applyStimulus(1'b0, MULT, 32'hFFFF_FFFD, 32'd7);
    checkOutput("mult_busy_start", {63'd0, busy}, 64'd1);
    checkOutput("mult_hilo_during_busy", {hi, lo}, 64'd0);
    waitDone(cycles, busyCycles, sawIllegal);
    checkOutput("mult_latency", 64'(cycles), 64'd33);
    checkOutput("mult_busy_cycles", 64'(busyCycles), 64'd33);
    checkOutput("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    checkOutput("mult_busy_at_done", {63'd0, busy}, 64'd0);
    @(posedge Clk); #1;
    checkOutput("mult_done_pulse", {63'd0, done}, 64'd0);

    $display("[TB] multu max*max");
    applyStimulus(1'b0, MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(cycles, busyCycles, sawIllegal);
    checkOutput("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    $display("[TB] moves and madd/msub");
    applyStimulus(1'b0, MTLO, 32'hFFFF_FFFF, 32'd0);
    checkOutput("mtlo_done", {62'd0, done, busy}, 64'd2);
    applyStimulus(1'b0, MTHI, 32'd0, 32'd0);
    checkOutput("mthi_hilo", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
    applyStimulus(1'b1, MADD, 32'd1, 32'd1);
    waitDone(cycles, busyCycles, sawIllegal);
    checkOutput("madd_hilo", {hi, lo}, 64'h0000_0001_0000_0000);
    applyStimulus(1'b1, MSUB, 32'd2, 32'd3);
    waitDone(cycles, busyCycles, sawIllegal);
    checkOutput("msub_hilo", {hi, lo}, 64'h0000_0000_FFFF_FFFA);

    applyStimulus(1'b0, MTHI, 32'h0000_1234, 32'd0);
    applyStimulus(1'b0, MFHI, 32'd0, 32'd0);
    checkOutput("mfhi_result", {32'd0, result}, 64'h1234);
    checkOutput("mfhi_done", {63'd0, done}, 64'd1);
    applyStimulus(1'b0, MFLO, 32'd0, 32'd0);
    checkOutput("mflo_result", {32'd0, result}, 64'hFFFF_FFFA);

    $display("[TB] illegal funct");
    applyStimulus(1'b0, 6'b111111, 32'hDEAD_BEEF, 32'd1);
    checkOutput("illegal_pulse", {62'd0, illegal, done}, 64'd2);
    checkOutput("illegal_hilo", {hi, lo}, 64'h0000_1234_FFFF_FFFA);
    checkOutput("illegal_busy", {63'd0, busy}, 64'd0);
    @(posedge Clk); #1;
    checkOutput("illegal_clears", {63'd0, illegal}, 64'd0);

`ifdef HILO_DIV_EN
    $display("[TB] divide");
    applyStimulus(1'b0, DIV, 32'hFFFF_FFF9, 32'd2);
    waitDone(cycles, busyCycles, sawIllegal);
    checkOutput("div_latency", 64'(cycles), 64'd33);
    checkOutput("div_neg7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    applyStimulus(1'b0, DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone(cycles, busyCycles, sawIllegal);
    checkOutput("div_minneg", {hi, lo}, 64'h0000_0000_8000_0000);
    applyStimulus(1'b0, DIVU, 32'd100, 32'd7);
    waitDone(cycles, busyCycles, sawIllegal);
    checkOutput("divu_100_7", {hi, lo}, 64'h0000_0002_0000_000E);
    applyStimulus(1'b0, DIV, 32'd5, 32'd0);
    waitDone(cycles, busyCycles, sawIllegal);
    checkOutput("divz_latency", 64'(cycles), 64'd1);
    checkOutput("divz_flag", {63'd0, div_zero}, 64'd1);
    checkOutput("divz_hilo", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
    @(posedge Clk); #1;
    checkOutput("divz_clears", {63'd0, div_zero}, 64'd0);
`else
    $display("[TB] divide disabled");
    applyStimulus(1'b0, DIV, 32'd5, 32'd1);
    checkOutput("div_illegal", {61'd0, illegal, done, busy}, 64'd4);
    checkOutput("div_illegal_hilo", {hi, lo}, 64'h0000_1234_FFFF_FFFA);
    checkOutput("div_illegal_dz", {63'd0, div_zero}, 64'd0);
`endif

    $display("[TB] handshake");
    applyStimulus(1'b0, MULT, 32'd6, 32'd7);
    applyStimulus(1'b0, DIVU, 32'd100, 32'd3);
    checkOutput("busy_start_no_illegal", {63'd0, illegal}, 64'd0);
    waitDone(cycles, busyCycles, sawIllegal);
    checkOutput("busy_start_latency", 64'(cycles), 64'd32);
    checkOutput("busy_start_ignored", {hi, lo}, 64'h0000_0000_0000_002A);
    checkOutput("busy_start_ill_seen", {63'd0, sawIllegal}, 64'd0);
    applyStimulus(1'b0, MULTU, 32'd3, 32'd5);
    checkOutput("b2b_accepted", {63'd0, busy}, 64'd1);
    waitDone(cycles, busyCycles, sawIllegal);
    checkOutput("b2b_latency", 64'(cycles), 64'd33);
    checkOutput("b2b_hilo", {hi, lo}, 64'h0000_0000_0000_000F);

    $display("[TB] async reset mid-mult");
    applyStimulus(1'b0, MULT, 32'd9, 32'd9);
    repeat (9) begin @(posedge Clk); #1; end
    #1;
    Reset = 1'b1;
    #1;
    checkOutput("arst_busy_done", {62'd0, busy, done}, 64'd0);
    checkOutput("arst_hilo", {hi, lo}, 64'd0);
    #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    applyStimulus(1'b0, MULTU, 32'h0001_0000, 32'h0001_0000);
    waitDone(cycles, busyCycles, sawIllegal);
    checkOutput("arst_next_latency", 64'(cycles), 64'd33);
    checkOutput("arst_next_hilo", {hi, lo}, 64'h0000_0001_0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
